mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single physical memory port between the fetch stage (instruction reads) and the memory-access stage (data reads and writes) of the RV32I pipeline. Sits between the pipeline's instruction/data memory interfaces and the one `pmem_*` port to the cache or main memory. It registers the granted request onto the shared port, routes the response back to the owner, and enforces one outstanding transaction at a time.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byte-enable width is `DATA_W/8`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset. Asynchronous, active-low.
- `inst_read` in 1: fetch read request; held until `inst_resp`.
- `inst_addr` in ADDR_W: fetch address, word aligned.
- `inst_resp` out 1: fetch transaction complete.
- `inst_rdata` out DATA_W: fetch read data; valid only while `inst_resp`=1.
- `data_read`, `data_write` in 1: data request; held until `data_resp`.
- `data_addr` in ADDR_W: data address, low 2 bits already zero.
- `data_wdata` in DATA_W: store data.
- `data_mbe` in DATA_W/8: store byte enables.
- `data_resp` out 1: data transaction complete.
- `data_rdata` out DATA_W: load data; valid only while `data_resp`=1.
- `pmem_read`, `pmem_write` out 1: shared-port command; registered.
- `pmem_address` out ADDR_W, `pmem_wdata` out DATA_W, `pmem_mbe` out DATA_W/8: registered.
- `pmem_resp` in 1: shared-port completion strobe, one cycle.
- `pmem_rdata` in DATA_W: shared-port read data.

## Operation
- FSM states: `IDLE`, `INST`, `DATA`.
- `IDLE`: no command is driven. If any request is pending at the edge, the FSM moves to the granted state and latches that requester's address, wdata, mbe, and read/write into the `pmem_*` registers.
- `INST`/`DATA`: the latched command is held stable until `pmem_resp`. `pmem_resp` is forwarded combinationally to the owner's `*_resp`, and `pmem_rdata` to the owner's `*_rdata`. The non-owner's resp is 0.
- At the edge with `pmem_resp`=1:
  - If the other requester is pending, go directly to its state and latch its command. This is back-to-back with no idle cycle.
  - Otherwise go to `IDLE`.
  - The same requester is never re-granted at this edge: its request is still high only because it deasserts the cycle after resp.
- Priority when both are pending in `IDLE`: see Configuration.
- `data_read` and `data_write` both high is illegal. Write wins, and a simulation-only assertion fires.
- Requests or request changes during another owner's transaction have no effect on the `pmem_*` outputs.
- `pmem_resp` in `IDLE` is ignored; no resp is generated.

## Timing
- Reset values:
  - FSM is `IDLE`.
  - `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, and `pmem_mbe` are all 0.
  - `inst_resp` and `data_resp` are 0.
  - The round-robin pointer (when compiled in) points to data.
- Reset asserted mid-transaction: the outputs above clear immediately. The transaction is abandoned and no resp is issued.
- Latency: a request seen at edge N produces the `pmem_*` command from N+1. With `pmem_resp` in cycle M, the requester sees resp in cycle M, i.e. 1 cycle overhead plus memory latency.
- Back-to-back: when the second requester is pending at completion, its `pmem_*` command is driven in cycle M+1.
- `pmem_*` outputs are glitch-free (registers). The resp and rdata paths are combinational from `pmem_resp`/`pmem_rdata`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: a 1-bit pointer grants the requester not most recently served when both are pending in `IDLE`. The pointer updates on every completion.
  - Undefined: fixed priority, with data always winning in `IDLE`.
- Back-to-back alternation at completion is identical in both builds.

## Structure
- Shared package `rv32i_types` holds:
  - the `arb_state_t` enum (`IDLE`, `INST`, `DATA`);
  - an `arb_owner_t` enum (`OWN_INST`, `OWN_DATA`);
  - a `mem_cmd_t` struct (addr, wdata, mbe, read, write) used for the latched command.
- One sub-module, `mem_arb_select`: combinational next-owner logic. Inputs are the pending bits, the current state, and the pointer. Isolating it lets both priority builds be unit tested.

## Test plan
- Fetch only: `inst_read`=1, `inst_addr`=0x60, memory responds after 3 cycles with 0x00000013 -> `pmem_read`=1 with address 0x60 from cycle 1; `inst_resp`=1 and `inst_rdata`=0x13 in the resp cycle; `IDLE` next.
- Store: `data_write`=1, addr 0x100, wdata 0xDEADBEEF, mbe 0x3 -> `pmem_write`=1 with exact address, wdata, and mbe held until resp; `data_resp` pulses for one cycle; `inst_resp` stays 0.
- Simultaneous requests in `IDLE` (fetch 0x0, load 0x200):
  - Without the macro, data is served first, then fetch back-to-back with no idle cycle.
  - With the macro after a prior data completion, fetch is served first.
- Both requests held across 6 transactions with the macro -> strict alternation; neither requester starves.
- Reset pulse asserted while `pmem_read`=1 -> all `pmem_*` outputs drop to 0 asynchronously; a later `pmem_resp` produces no resp.
- `pmem_resp`=1 while in `IDLE` -> no resp output and no state change.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the fetch/data memory port arbiter
// Contents: arb_state_t (FSM states), arb_owner_t (requester identity),
//           mem_cmd_t (command latched onto the shared pmem port).
package rv32i_types;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   wdata;
    logic [MEM_DATA_W/8-1:0] mbe;
    logic                    read;
    logic                    write;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline-side and shared-port signals of the memory port arbiter
// Ports: inst_* (fetch request/response), data_* (load/store request/response),
//        pmem_* (shared memory port). Modport slave is the arbiter's view;
//        modport master is the view of the pipeline plus memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  inst_read;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_resp;
  logic [DATA_W-1:0]     inst_rdata;

  logic                  data_read;
  logic                  data_write;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic [DATA_W/8-1:0]   data_mbe;
  logic                  data_resp;
  logic [DATA_W-1:0]     data_rdata;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_W-1:0]     pmem_address;
  logic [DATA_W-1:0]     pmem_wdata;
  logic [DATA_W/8-1:0]   pmem_mbe;
  logic                  pmem_resp;
  logic [DATA_W-1:0]     pmem_rdata;

  modport slave (
    input  inst_read, inst_addr,
    input  data_read, data_write, data_addr, data_wdata, data_mbe,
    input  pmem_resp, pmem_rdata,
    output inst_resp, inst_rdata, data_resp, data_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_mbe
  );

  modport master (
    output inst_read, inst_addr,
    output data_read, data_write, data_addr, data_wdata, data_mbe,
    output pmem_resp, pmem_rdata,
    input  inst_resp, inst_rdata, data_resp, data_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_mbe
  );
endinterface

// File: rtl/mem_port_arbiter_select.sv
// rtl/mem_port_arbiter_select.sv - combinational next-owner choice for the memory port arbiter
// Ports: inst_pend/data_pend (pending requests), state (current FSM state),
//        ptr (last requester served), grant (someone may take the port), owner (who).
// Build option MEM_ARB_ROUND_ROBIN_EN: contention in IDLE goes to the requester
// not served last; otherwise data always wins.
module mem_arb_select
  import rv32i_types::*;
(
  input  logic       inst_pend,
  input  logic       data_pend,
  input  arb_state_t state,
  input  arb_owner_t ptr,
  output logic       grant,
  output arb_owner_t owner
);

  always_comb begin
    grant = 1'b0;
    owner = OWN_DATA;
    case (state)
      IDLE: begin
        grant = inst_pend | data_pend;
        if (inst_pend && data_pend)
`ifdef MEM_ARB_ROUND_ROBIN_EN
          owner = (ptr == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
          owner = OWN_DATA;
`endif
        else
          owner = data_pend ? OWN_DATA : OWN_INST;
      end
      // At completion only the other requester can be handed the port; the
      // finishing requester still shows its request for one more cycle.
      INST: begin
        grant = data_pend;
        owner = OWN_DATA;
      end
      DATA: begin
        grant = inst_pend;
        owner = OWN_INST;
      end
      default: begin
        grant = 1'b0;
        owner = OWN_DATA;
      end
    endcase
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_ptr;
  assign unused_ptr = ptr;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data stages
// Ports: clk, rst (async, active-low), bus (mem_port_arbiter_if.slave):
//        inst_*/data_* pipeline requests and responses, pmem_* registered shared port.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin contention handling.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t state;
  mem_cmd_t   cmd;
  arb_owner_t ptr;
  arb_owner_t next_owner;
  logic       grant;
  logic       done;
  logic       inst_pend;
  logic       data_pend;
  mem_cmd_t   inst_cmd;
  mem_cmd_t   data_cmd;

  logic [ADDR_W-1:0]   inst_addr;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic [DATA_W/8-1:0] data_mbe;

  assign inst_addr  = bus.inst_addr;
  assign data_addr  = bus.data_addr;
  assign data_wdata = bus.data_wdata;
  assign data_mbe   = bus.data_mbe;

  assign inst_pend = bus.inst_read;
  assign data_pend = bus.data_read | bus.data_write;
  // A strobe seen in IDLE belongs to nobody and is dropped.
  assign done      = (state != IDLE) && bus.pmem_resp;

  always_comb begin
    inst_cmd       = '0;
    inst_cmd.addr  = inst_addr;
    inst_cmd.read  = 1'b1;
    data_cmd       = '0;
    data_cmd.addr  = data_addr;
    data_cmd.wdata = data_wdata;
    data_cmd.mbe   = data_mbe;
    // Write wins if both strobes are (illegally) high.
    data_cmd.write = bus.data_write;
    data_cmd.read  = bus.data_read & ~bus.data_write;
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  assign ptr = OWN_DATA;
`endif

  mem_arb_select u_select (
    .inst_pend (inst_pend),
    .data_pend (data_pend),
    .state     (state),
    .ptr       (ptr),
    .grant     (grant),
    .owner     (next_owner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cmd   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr   <= OWN_DATA;
`endif
    end else if (state == IDLE || done) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (done)
        ptr <= (state == INST) ? OWN_INST : OWN_DATA;
`endif
      if (grant) begin
        state <= (next_owner == OWN_INST) ? INST : DATA;
        cmd   <= (next_owner == OWN_INST) ? inst_cmd : data_cmd;
      end else begin
        state <= IDLE;
        cmd   <= '0;
      end
    end
  end

  assign bus.pmem_read    = cmd.read;
  assign bus.pmem_write   = cmd.write;
  assign bus.pmem_address = cmd.addr;
  assign bus.pmem_wdata   = cmd.wdata;
  assign bus.pmem_mbe     = cmd.mbe;

  assign bus.inst_resp  = (state == INST) && bus.pmem_resp;
  assign bus.data_resp  = (state == DATA) && bus.pmem_resp;
  assign bus.inst_rdata = bus.inst_resp ? bus.pmem_rdata : '0;
  assign bus.data_rdata = bus.data_resp ? bus.pmem_rdata : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst)
      assert (!(bus.data_read && bus.data_write))
        else $error("mem_port_arbiter: data_read and data_write both high, write taken");
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import rv32i_types::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // reference model: 0 = port idle, 1 = fetch owns it, 2 = data owns it
  int          m_owner = 0;
  int          last_served = 2;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_mbe;
  logic        e_read, e_write;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_grant(input int who);
    m_owner = who;
    if (who == 1) begin
      e_addr = bus.inst_addr; e_read = 1'b1; e_write = 1'b0; e_wdata = '0; e_mbe = '0;
    end else begin
      e_addr = bus.data_addr; e_read = bus.data_read; e_write = bus.data_write;
      e_wdata = bus.data_wdata; e_mbe = bus.data_mbe;
    end
  endtask

  initial begin
    logic        i_drop, d_drop, busy, exp_i, exp_d, pend_i, pend_d;
    int          lat, i_issued, d_issued, i_done, d_done;
    logic [31:0] first_addr, second_addr;

    rst = 1'b0;
    bus.inst_read = 0; bus.inst_addr = '0;
    bus.data_read = 0; bus.data_write = 0; bus.data_addr = '0;
    bus.data_wdata = '0; bus.data_mbe = '0;
    bus.pmem_resp = 0; bus.pmem_rdata = '0;
    tick(); tick();

    // reset state
    chk("rst_pmem_read", bus.pmem_read, 0);
    chk("rst_pmem_write", bus.pmem_write, 0);
    chk("rst_pmem_address", bus.pmem_address, 0);
    chk("rst_pmem_wdata", bus.pmem_wdata, 0);
    chk("rst_pmem_mbe", bus.pmem_mbe, 0);
    chk("rst_inst_resp", bus.inst_resp, 0);
    chk("rst_data_resp", bus.data_resp, 0);
    rst = 1'b1;
    tick();

    // fetch only, memory answers in the third command cycle
    bus.inst_read = 1; bus.inst_addr = 32'h60;
    tick();
    chk("fetch_pmem_read", bus.pmem_read, 1);
    chk("fetch_pmem_address", bus.pmem_address, 32'h60);
    chk("fetch_pmem_write", bus.pmem_write, 0);
    chk("fetch_inst_resp_early", bus.inst_resp, 0);
    tick(); tick();
    chk("fetch_hold_read", bus.pmem_read, 1);
    bus.pmem_resp = 1; bus.pmem_rdata = 32'h13;
    #1;
    chk("fetch_inst_resp", bus.inst_resp, 1);
    chk("fetch_inst_rdata", bus.inst_rdata, 32'h13);
    chk("fetch_data_resp", bus.data_resp, 0);
    tick();
    bus.pmem_resp = 0; bus.inst_read = 0;
    chk("fetch_idle_after", bus.pmem_read, 0);
    tick();
    chk("fetch_no_regrant", bus.pmem_read, 0);

    // store
    bus.data_write = 1; bus.data_addr = 32'h100; bus.data_wdata = 32'hDEADBEEF; bus.data_mbe = 4'h3;
    tick();
    chk("store_pmem_write", bus.pmem_write, 1);
    chk("store_pmem_read", bus.pmem_read, 0);
    chk("store_pmem_address", bus.pmem_address, 32'h100);
    chk("store_pmem_wdata", bus.pmem_wdata, 32'hDEADBEEF);
    chk("store_pmem_mbe", bus.pmem_mbe, 4'h3);
    tick();
    chk("store_hold_wdata", bus.pmem_wdata, 32'hDEADBEEF);
    bus.pmem_resp = 1; bus.pmem_rdata = 32'h55;
    #1;
    chk("store_data_resp", bus.data_resp, 1);
    chk("store_inst_resp", bus.inst_resp, 0);
    tick();
    bus.pmem_resp = 0; bus.data_write = 0;
    #1;
    chk("store_data_resp_pulse", bus.data_resp, 0);
    chk("store_idle_after", bus.pmem_write, 0);

    // simultaneous fetch 0x0 and load 0x200
    tick();
    bus.inst_read = 1; bus.inst_addr = 32'h0;
    bus.data_read = 1; bus.data_addr = 32'h200;
    first_addr  = RR ? 32'h0 : 32'h200;
    second_addr = RR ? 32'h200 : 32'h0;
    tick();
    chk("simul_first_addr", bus.pmem_address, first_addr);
    chk("simul_first_read", bus.pmem_read, 1);
    tick();
    bus.pmem_resp = 1; bus.pmem_rdata = 32'hA5A5_0001;
    #1;
    chk("simul_first_inst_resp", bus.inst_resp, RR ? 1 : 0);
    chk("simul_first_data_resp", bus.data_resp, RR ? 0 : 1);
    tick();
    bus.pmem_resp = 0;
    if (RR) bus.inst_read = 0; else bus.data_read = 0;
    chk("simul_b2b_addr", bus.pmem_address, second_addr);
    chk("simul_b2b_read", bus.pmem_read, 1);
    bus.pmem_resp = 1; bus.pmem_rdata = 32'hA5A5_0002;
    #1;
    chk("simul_second_inst_resp", bus.inst_resp, RR ? 0 : 1);
    chk("simul_second_data_resp", bus.data_resp, RR ? 1 : 0);
    tick();
    bus.pmem_resp = 0; bus.inst_read = 0; bus.data_read = 0;
    chk("simul_idle_after", bus.pmem_read, 0);

    // stray strobe in IDLE
    tick();
    bus.pmem_resp = 1; bus.pmem_rdata = 32'h1234;
    #1;
    chk("idle_resp_inst", bus.inst_resp, 0);
    chk("idle_resp_data", bus.data_resp, 0);
    tick();
    bus.pmem_resp = 0;
    chk("idle_resp_no_cmd", bus.pmem_read | bus.pmem_write, 0);

    // reset in the middle of a fetch
    bus.inst_read = 1; bus.inst_addr = 32'h60;
    tick();
    chk("midrst_pre_read", bus.pmem_read, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_async_read", bus.pmem_read, 0);
    chk("midrst_async_addr", bus.pmem_address, 0);
    bus.inst_read = 0;
    tick();
    bus.pmem_resp = 1;
    #1;
    chk("midrst_no_resp", bus.inst_resp | bus.data_resp, 0);
    rst = 1'b1;
    tick();
    bus.pmem_resp = 0;
    chk("midrst_idle", bus.pmem_read, 0);

    // randomized traffic against the reference model
    m_owner = 0; last_served = 2;
    i_drop = 0; d_drop = 0; busy = 0; lat = 0;
    i_issued = 0; d_issued = 0; i_done = 0; d_done = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      bus.pmem_resp = 0;
      if (m_owner == 0) begin
        chk("rnd_idle_cmd", {bus.pmem_read, bus.pmem_write}, 2'b00);
      end else begin
        chk("rnd_addr", bus.pmem_address, e_addr);
        chk("rnd_rw", {bus.pmem_read, bus.pmem_write}, {e_read, e_write});
        if (m_owner == 2) chk("rnd_wdata_mbe", {bus.pmem_wdata, bus.pmem_mbe}, {e_wdata, e_mbe});
      end

      if (i_drop) begin
        bus.inst_read = 0; i_drop = 0;
      end else if (!bus.inst_read && cyc < 600 && $urandom_range(0, 2) == 0) begin
        bus.inst_read = 1; bus.inst_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        i_issued++;
      end
      if (d_drop) begin
        bus.data_read = 0; bus.data_write = 0; d_drop = 0;
      end else if (!(bus.data_read || bus.data_write) && cyc < 600 && $urandom_range(0, 2) == 0) begin
        bus.data_write = 1'($urandom_range(0, 1));
        bus.data_read  = ~bus.data_write;
        bus.data_addr  = {20'h1, 10'($urandom_range(0, 1023)), 2'b00};
        bus.data_wdata = $urandom;
        bus.data_mbe   = 4'($urandom_range(0, 15));
        d_issued++;
      end

      if (bus.pmem_read || bus.pmem_write) begin
        if (!busy) begin busy = 1; lat = $urandom_range(0, 3); end
        if (lat == 0) begin
          bus.pmem_resp = 1; bus.pmem_rdata = $urandom; busy = 0;
        end else lat--;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.pmem_resp = 1; bus.pmem_rdata = $urandom;
      end
      #1;

      exp_i = (m_owner == 1) && bus.pmem_resp;
      exp_d = (m_owner == 2) && bus.pmem_resp;
      chk("rnd_inst_resp", bus.inst_resp, exp_i);
      chk("rnd_data_resp", bus.data_resp, exp_d);
      if (exp_i) begin chk("rnd_inst_rdata", bus.inst_rdata, bus.pmem_rdata); i_drop = 1; i_done++; end
      if (exp_d) begin chk("rnd_data_rdata", bus.data_rdata, bus.pmem_rdata); d_drop = 1; d_done++; end

      pend_i = bus.inst_read;
      pend_d = bus.data_read | bus.data_write;
      if (m_owner != 0 && bus.pmem_resp) begin
        last_served = m_owner;
        if (m_owner == 1 && pend_d) model_grant(2);
        else if (m_owner == 2 && pend_i) model_grant(1);
        else m_owner = 0;
      end else if (m_owner == 0) begin
        if (pend_i && pend_d) model_grant((RR && last_served == 2) ? 1 : 2);
        else if (pend_d) model_grant(2);
        else if (pend_i) model_grant(1);
      end
      tick();
    end
    bus.pmem_resp = 0;
    chk("rnd_fetch_all_served", i_done, i_issued);
    chk("rnd_data_all_served", d_done, d_issued);
    chk("rnd_fetch_traffic_seen", (i_issued > 10), 1);
    chk("rnd_data_traffic_seen", (d_issued > 10), 1);
    chk("rnd_final_idle", {bus.pmem_read, bus.pmem_write}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
